// File: rtl/comnet_pkg.sv
// Shared widths, opcode encodings and FSM states for the comnet link master.
package comnet_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int CMD_W    = 1 + ADDR_W + DATA_W;
  localparam int BITCNT_W = 6;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    WAIT_RESP,
    STATUS,
    RDATA,
    STOP,
    DONE
  } state_t;

endpackage

// File: rtl/comnet_sclk_gen.sv
// SCl generator: a bit is CLK_DIV cycles low followed by CLK_DIV cycles high.
// After clear the generator sits at the start of a high phase, so the START
// condition is simply the first high phase with SDa pulled low.
module comnet_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic scl,
  output logic fall_tick,
  output logic sample_tick,
  output logic rise_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_LAST);

  // The last high cycle is both the RDa sample point and the cycle on which
  // the next SDa value is registered, so that SDa moves together with SCl fall.
  assign fall_tick   = en & scl & last;
  assign sample_tick = en & scl & last;
  assign rise_tick   = en & ~scl & last;

  // Half-period counter and SCl phase register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      scl <= 1'b1;
    end else if (en) begin
      if (last) begin
        cnt <= '0;
        scl <= ~scl;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/comnet_master.sv
// comnet register-link initiator: serialises a read/write request onto
// SDa/SCl, collects the target's response on RDa and reports status.
module comnet_master
  import comnet_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int RESP_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        nack,
  output logic        unknown,
  output logic        timeout,
  output logic        SDa,
  output logic        SCl,
  input  logic        RDa
);

  localparam int WAIT_W = $clog2(RESP_WAIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LOAD   = WAIT_W'(RESP_WAIT - 1);
  localparam logic [BITCNT_W-1:0] WR_CMD_LAST = BITCNT_W'(CMD_W - 1);
  localparam logic [BITCNT_W-1:0] RD_CMD_LAST = BITCNT_W'(ADDR_W);
  localparam logic [BITCNT_W-1:0] DATA_LAST   = BITCNT_W'(DATA_W - 1);

  state_t state, state_n;

  logic                gen_en, gen_clr;
  logic                scl_gen, fall_tick, sample_tick, rise_tick;
  logic                rda_p0, rda_p1;
  logic                sda;
  logic                stop_hi;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                op;
  logic [CMD_W-1:0]    cmd_sr;
  logic                ack_bit;
  logic [DATA_W-2:0]   shadow;
  logic                read_ack;

  comnet_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk        (clk),
    .rst        (rst),
    .en         (gen_en),
    .clr        (gen_clr),
    .scl        (scl_gen),
    .fall_tick  (fall_tick),
    .sample_tick(sample_tick),
    .rise_tick  (rise_tick)
  );

  // During the final STOP phase the generator keeps counting a low phase for
  // timing, but SCl is held high so SDa can rise as the stop condition.
  assign SCl = scl_gen | stop_hi;
  assign SDa = sda;

  assign read_ack = (op == OP_READ) && ack_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode plus busy/done/generator controls.
  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    done    = (state == DONE);
    gen_en  = 1'b0;
    gen_clr = 1'b0;
    case (state)
      IDLE: begin
        gen_clr = 1'b1;
        if (start) state_n = START;
      end
      START: begin
        gen_en = 1'b1;
        if (fall_tick) state_n = CMD;
      end
      CMD: begin
        gen_en = 1'b1;
        if (fall_tick && bit_cnt == '0) state_n = WAIT_RESP;
      end
      WAIT_RESP: begin
        gen_en = 1'b1;
        if (sample_tick) begin
          if (rda_p1)              state_n = STATUS;
          else if (wait_cnt == '0) state_n = STOP;
        end
      end
      STATUS: begin
        gen_en = 1'b1;
        if (sample_tick && bit_cnt == '0) state_n = read_ack ? RDATA : STOP;
      end
      RDATA: begin
        gen_en = 1'b1;
        if (sample_tick && bit_cnt == '0) state_n = STOP;
      end
      STOP: begin
        gen_en = 1'b1;
        if (stop_hi && rise_tick) state_n = DONE;
      end
      DONE: begin
        gen_clr = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control path: RDa synchroniser, SDa, counters, status flags and rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      rda_p0   <= 1'b0;
      rda_p1   <= 1'b0;
      sda      <= 1'b1;
      stop_hi  <= 1'b0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      ack      <= 1'b0;
      nack     <= 1'b0;
      unknown  <= 1'b0;
      timeout  <= 1'b0;
      rdata    <= '0;
    end else begin
      rda_p0 <= RDa;
      rda_p1 <= rda_p0;
      case (state)
        IDLE: begin
          sda     <= 1'b1;
          stop_hi <= 1'b0;
          if (start) begin
            sda     <= 1'b0;
            ack     <= 1'b0;
            nack    <= 1'b0;
            unknown <= 1'b0;
            timeout <= 1'b0;
          end
        end
        START: begin
          if (fall_tick) begin
            sda     <= cmd_sr[CMD_W-1];
            bit_cnt <= (op == OP_WRITE) ? WR_CMD_LAST : RD_CMD_LAST;
          end
        end
        CMD: begin
          if (fall_tick) begin
            if (bit_cnt == '0) begin
              sda      <= 1'b1;
              wait_cnt <= WAIT_LOAD;
            end else begin
              sda     <= cmd_sr[CMD_W-1];
              bit_cnt <= bit_cnt - BITCNT_W'(1);
            end
          end
        end
        WAIT_RESP: begin
          if (sample_tick) begin
            if (rda_p1) begin
              bit_cnt <= BITCNT_W'(1);
            end else if (wait_cnt == '0) begin
              timeout <= 1'b1;
              sda     <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end
        end
        STATUS: begin
          if (sample_tick) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - BITCNT_W'(1);
            end else begin
              ack     <= ack_bit;
              nack    <= ~ack_bit;
              unknown <= rda_p1;
              if (read_ack) bit_cnt <= DATA_LAST;
              else          sda     <= 1'b0;
            end
          end
        end
        RDATA: begin
          if (sample_tick) begin
            if (bit_cnt == '0) begin
              rdata <= {shadow, rda_p1};
              sda   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - BITCNT_W'(1);
            end
          end
        end
        STOP: begin
          if (fall_tick && !stop_hi) begin
            sda     <= 1'b1;
            stop_hi <= 1'b1;
          end
        end
        DONE: begin
          sda     <= 1'b1;
          stop_hi <= 1'b0;
        end
        default: sda <= 1'b1;
      endcase
    end
  end

  // Data path: request latch, command shifter, first status bit, read shadow.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op     <= wr;
      cmd_sr <= {wr, addr, wdata};
    end else if ((state == START || state == CMD) && fall_tick) begin
      cmd_sr <= {cmd_sr[CMD_W-2:0], 1'b0};
    end
    if (state == STATUS && sample_tick && bit_cnt != '0) ack_bit <= rda_p1;
    if (state == RDATA && sample_tick) shadow <= {shadow[DATA_W-3:0], rda_p1};
  end

endmodule
